// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result with a start/busy/done handshake and an iterative 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to build a single-cycle barrel shifter instead (busy tied low).

`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SUB  4'b1000
`define ALU_SLL  4'b0001
`define ALU_SLT  4'b0010
`define ALU_SLTU 4'b0011
`define ALU_XOR  4'b0100
`define ALU_SRL  4'b0101
`define ALU_SRA  4'b1101
`define ALU_OR   4'b0110
`define ALU_AND  4'b0111
`endif

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ALUControl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

    state_t      state, state_n;
    shift_kind_t kind, kind_n;
    logic [31:0] acc, acc_n, acc_step;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] result_n;
    logic        done_n;

    logic [31:0] alu_out;
    logic        is_shift;
    shift_kind_t op_kind;
    logic [4:0]  shamt;

    assign shamt = b[4:0];

    always_comb begin
        is_shift = 1'b0;
        op_kind  = SK_SLL;
        case (ALUControl)
            `ALU_SLL: begin is_shift = 1'b1; op_kind = SK_SLL; end
            `ALU_SRL: begin is_shift = 1'b1; op_kind = SK_SRL; end
            `ALU_SRA: begin is_shift = 1'b1; op_kind = SK_SRA; end
            default:  ;
        endcase
    end

    // Single-cycle datapath; in the iterative build shifts only reach here with shamt 0.
    always_comb begin
        alu_out = a + b;
        case (ALUControl)
            `ALU_SUB:  alu_out = a - b;
            `ALU_SLT:  alu_out = {31'b0, $signed(a) < $signed(b)};
            `ALU_SLTU: alu_out = {31'b0, a < b};
            `ALU_XOR:  alu_out = a ^ b;
            `ALU_OR:   alu_out = a | b;
            `ALU_AND:  alu_out = a & b;
`ifdef ALU_FAST_SHIFT_EN
            `ALU_SLL:  alu_out = a << shamt;
            `ALU_SRL:  alu_out = a >> shamt;
            `ALU_SRA:  alu_out = $unsigned($signed(a) >>> shamt);
`else
            `ALU_SLL, `ALU_SRL, `ALU_SRA: alu_out = a;
`endif
            default:   alu_out = a + b;
        endcase
    end

    always_comb begin
        case (kind)
            SK_SLL:  acc_step = {acc[30:0], 1'b0};
            SK_SRL:  acc_step = {1'b0, acc[31:1]};
            default: acc_step = {acc[31], acc[31:1]};
        endcase
    end

    always_comb begin
        state_n  = state;
        kind_n   = kind;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = result;
        done_n   = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef ALU_FAST_SHIFT_EN
                        result_n = alu_out;
                        done_n   = 1'b1;
`else
                        if (is_shift && (shamt != 5'd0)) begin
                            acc_n   = a;
                            cnt_n   = shamt;
                            kind_n  = op_kind;
                            state_n = SHIFT;
                        end else begin
                            result_n = alu_out;
                            done_n   = 1'b1;
                        end
`endif
                    end
                end
                SHIFT: begin
                    acc_n = acc_step;
                    cnt_n = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result_n = acc_step;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            kind   <= SK_SLL;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            kind   <= kind_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            result <= result_n;
            done   <= done_n;
        end
    end

`ifdef ALU_FAST_SHIFT_EN
    assign busy = 1'b0;
`else
    assign busy = (state == SHIFT);
`endif
    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expectations adapt to ALU_FAST_SHIFT_EN.
module tb_alu_exec_unit;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_BAD  = 4'b1001;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  ALUControl = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUControl (ALUControl),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a single edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        ALUControl = op;
        a = av;
        b = bv;
        tick();
        start = 1'b0;
        a = 32'hA5A5_A5A5;
        b = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 64) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp, input int exp_edges);
        int e, bc;
        issue(op, av, bv);
        wait_done(e, bc);
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".result"}, result, exp);
        check_eq({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
        check_eq({tag, ".latency"}, 32'(e), 32'(exp_edges));
        check_eq({tag, ".busy_cycles"}, 32'(bc), 32'(exp_edges));
        tick();
        check_eq({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int e, bc, pulses;

        tick();
        check_eq("rst.result", result, 32'd0);
        check_eq("rst.zero", 32'(zero), 32'd1);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a long shift
        issue(OP_SLL, 32'd1, 32'd20);
        check_eq("midrst.busy_after_e0", 32'(busy), 32'(!FAST));
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst.busy", 32'(busy), 32'd0);
        check_eq("midrst.done", 32'(done), 32'd0);
        check_eq("midrst.result", result, 32'd0);
        check_eq("midrst.zero", 32'(zero), 32'd1);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            tick();
            if (done) pulses++;
        end
        check_eq("midrst.no_done", 32'(pulses), 32'd0);

        run("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        run("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        run("slt", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 0);
        run("sltu", OP_SLTU, 32'h8000_0000, 32'd1, 32'd0, 0);
        run("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
        run("undef_as_add", OP_BAD, 32'd3, 32'd4, 32'd7, 0);
        run("sra31", OP_SRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, FAST ? 0 : 31);
        run("srl31", OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, FAST ? 0 : 31);
        run("sll4", OP_SLL, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, FAST ? 0 : 4);
        run("sll0", OP_SLL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 0);

        // XOR held during a 10-step shift: ignored while busy, accepted in the done cycle
        start = 1'b1;
        ALUControl = OP_SLL;
        a = 32'd1;
        b = 32'd10;
        tick();
        ALUControl = OP_XOR;
        a = 32'h0000_00F0;
        b = 32'h0000_000F;
        wait_done(e, bc);
        check_eq("hold.shift_done", 32'(done), 32'd1);
        check_eq("hold.shift_result", result, 32'h0000_0400);
        check_eq("hold.shift_latency", 32'(e), FAST ? 32'd0 : 32'd10);
        check_eq("hold.busy_in_done", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check_eq("hold.xor_done", 32'(done), 32'd1);
        check_eq("hold.xor_result", result, 32'h0000_00FF);
        tick();
        check_eq("hold.xor_done_drop", 32'(done), 32'd0);

        // Flush at the third cycle of SRL by 8
        issue(OP_SRL, 32'h0000_FF00, 32'd8);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush.busy", 32'(busy), 32'd0);
        check_eq("flush.done", 32'(done), 32'd0);
        pulses = 0;
        repeat (12) begin
            tick();
            if (done) pulses++;
        end
        check_eq("flush.no_done", 32'(pulses), 32'd0);
        check_eq("flush.result", result, 32'h0000_00FF);

        // Flush beats a same-cycle start
        start = 1'b1;
        flush = 1'b1;
        ALUControl = OP_ADD;
        a = 32'd1;
        b = 32'd1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check_eq("flushstart.done", 32'(done), 32'd0);
        check_eq("flushstart.busy", 32'(busy), 32'd0);
        tick();
        check_eq("flushstart.done_late", 32'(done), 32'd0);
        check_eq("flushstart.result", result, 32'h0000_00FF);
        check_eq("flushstart.zero", 32'(zero), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the 4-bit `ALUControl` code produced by ALU control decode, plus the two 32-bit operands, and returns a registered 32-bit result with a start/busy/done handshake. Non-shift operations complete in one cycle. Shifts run as an iterative 1-bit-per-cycle engine unless the fast barrel shifter is compiled in. It sits between the ID/EX operands and the EX/MEM result capture, and supplies `busy` to the hazard/stall logic.

## Interface
- No parameters; datapath width fixed at 32, operation codes are the `ALU_*` macros from `rtl/isa.v`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled at rising edge, accepted only when `busy`=0.
- `ALUControl`  in  4  operation code (`ALU_ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND`).
- `a`  in  32  operand A (rs1).
- `b`  in  32  operand B (rs2/imm); shifts use `b[4:0]` only.
- `flush`  in  1  synchronous abort of any in-flight op.
- `busy`  out  1  multi-cycle shift in progress; new `start` ignored.
- `done`  out  1  one-cycle pulse: `result` updated this cycle.
- `result`  out  32  registered result; holds until next `done`.
- `zero`  out  1  combinational `result == 0`.

## Operation
- States: IDLE, SHIFT.
- IDLE, `start`=1, non-shift op: compute and register `result`, pulse `done`; stay IDLE.
  - ADD/SUB: modulo 2^32. SLT: signed compare, result 1/0 zero-extended. SLTU: unsigned compare. XOR/OR/AND: bitwise.
  - Undefined `ALUControl` codes: treated as ADD.
- IDLE, `start`=1, shift op, shamt N=`b[4:0]`:
  - N=0: `result`=`a`, `done` pulse, stay IDLE.
  - N>0: latch `acc`=`a`, `cnt`=N, op kind; go SHIFT. Operands may change after acceptance.
- SHIFT: each edge shift `acc` by 1 (SLL: zero in at LSB; SRL: zero in at MSB; SRA: `acc[31]` replicated), `cnt`-=1. On the edge where `cnt` goes 1→0: `result`=`acc` shifted, `done` pulse, go IDLE.
- `start` while `busy`: ignored, no queueing. Upstream holds `start` until `busy`=0.
- `flush`=1: next edge forces IDLE, no `done`, `result` unchanged. `flush` and `start` in the same cycle: `flush` wins, request dropped.
- Reset (async, any time incl. mid-shift): state IDLE, `busy`=0, `done`=0, `result`=0 (so `zero`=1), `acc`=0, `cnt`=0.

## Timing
- Start sampled at edge E0. Latency to `done`: 1 cycle for non-shift ops and N=0 shifts; N cycles for shifts with N>0 (`done` high after edge E0+N). Worst case 31.
- `busy`=1 from after E0 until the edge producing `done`. `busy`=0 in the `done` cycle, so back-to-back accept is allowed there.
- Non-shift throughput: one op per cycle, `busy` never asserted.
- `done` is never high for two consecutive cycles unless two ops were accepted back-to-back.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: single-cycle barrel shifter. Every op, including all shifts, has 1-cycle latency. SHIFT state and `busy` are never entered (`busy` tied 0).
- Not defined: iterative shifter as specified above, minimal area.

## Test plan
- Reset mid-shift: SLL a=1, b=20, assert `rst_n`=0 at cycle 5 -> `busy`=0, `done`=0, `result`=0, `zero`=1; no `done` after release.
- ADD a=0xFFFFFFFF, b=1 -> `done` after 1 cycle, `result`=0, `zero`=1. SUB a=5, b=7 -> 0xFFFFFFFE. SLT a=0x80000000, b=1 -> 1. SLTU same operands -> 0.
- SRA a=0x80000000, b=0x1F -> `busy` for 31 cycles, `done` at E0+31, `result`=0xFFFFFFFF. SRL same operands -> 0x00000001. SLL a=0x1, b=0x24 (shamt 4) -> 0x10 at E0+4.
- Shift with shamt 0: SLL a=0x1234, b=0x20 -> `result`=0x1234 after 1 cycle, `busy` never 1.
- Hold `start` with XOR during a 10-cycle shift -> ignored while `busy`; accepted in the `done` cycle, XOR `done` one cycle later.
- `flush` at cycle 3 of SRL N=8 -> no `done`, `result` retains previous value. Same-cycle `start`+`flush` -> no `done`. Repeat with `ALU_FAST_SHIFT_EN`: all shifts 1-cycle, `busy` stays 0.
